pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline; drives per-stage EN/FLUSH of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC enable.
- Arbitrates imem/dmem wait states (ihit/dhit), load-use hazards, taken-branch/jump squash (resolved in EX/MEM) and halt.
- Keeps a registered dmem-done latch, a RUN/HALT FSM and two saturating performance counters.

Parameters:
REGW, 5, register-select width
CNTW, 16, performance counter width

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, asynchronous, active-low
ihit  in  1  imem response valid this cycle
dhit  in  1  dmem response valid this cycle
id_rs  in  REGW  rs field of instr in IF/ID
id_rt  in  REGW  rt field of instr in IF/ID
id_uses_rt  in  1  IF/ID instr reads rt
ex_dREN  in  1  instr in ID/EX is a load
ex_wsel  in  REGW  destination reg of instr in ID/EX
mem_dREN  in  1  instr in EX/MEM reads dmem
mem_dWEN  in  1  instr in EX/MEM writes dmem
mem_branch_taken  in  1  EX/MEM instr redirects PC (taken branch/jump/jr)
wb_halt  in  1  halt flag in MEM/WB
IF_EN, ID_EN, EX_EN, MEM_EN  out  1 each  stage register enables
IF_FLUSH, ID_FLUSH, EX_FLUSH, MEM_FLUSH  out  1 each  stage clears (effective only with EN)
pc_en  out  1  PC register update
pc_redirect  out  1  select branch target for PC
imemREN  out  1  imem read request
dmemREN  out  1  dmem read request
dmemWEN  out  1  dmem write request
halt  out  1  registered halt indication
stall_cnt  out  CNTW  stall cycles
flush_cnt  out  CNTW  squash events

Behaviour:
- Reset: FSM=RUN, dmem_done=0, halt=0, stall_cnt=0, flush_cnt=0. All other outputs are combinational from these registers and the inputs.
- mem_acc = mem_dREN|mem_dWEN.
- dready = !mem_acc | dhit | dmem_done.
- load_use = ex_dREN & (ex_wsel!=0) & (ex_wsel==id_rs | (id_uses_rt & ex_wsel==id_rt)).
- step = (FSM==RUN) & !wb_halt & ihit & dready.
- step=0: all EN=0, all FLUSH=0, pc_en=0, pc_redirect=0. The pipeline freezes and all stage contents are held.
- step & mem_branch_taken: this case has priority over load_use.
  - All EN=1; IF_FLUSH=ID_FLUSH=EX_FLUSH=1; MEM_FLUSH=0.
  - pc_en=1; pc_redirect=1.
- step & !mem_branch_taken & load_use:
  - IF_EN=0; pc_en=0, so IF/ID and the PC are held.
  - ID_EN=1 with ID_FLUSH=1, inserting a bubble into ID/EX.
  - EX_EN=MEM_EN=1; no other flush.
- step, no hazard: all EN=1, no flush, pc_en=1, pc_redirect=0.
- MEM_FLUSH is never asserted in RUN.
- dmem_done:
  - Set at the edge where dhit=1 & mem_acc & !step (data served while waiting on ihit).
  - Cleared at any edge where step=1.
  - Its purpose is to prevent re-issuing the access.
- imemREN = (FSM==RUN) & !wb_halt.
- dmemREN = (FSM==RUN) & !wb_halt & mem_dREN & !dmem_done.
- dmemWEN: same form as dmemREN, using mem_dWEN.
- FSM:
  - RUN -> HALT at an edge with wb_halt=1.
  - HALT is absorbing; only nRST exits it.
  - In HALT: all EN/FLUSH=0, pc_en=0, all mem requests=0, halt=1 (registered, asserted starting the cycle after the transition edge).
- stall_cnt increments at each RUN edge where step=0, or step & load_use & !mem_branch_taken. It saturates at 2^CNTW-1 and is frozen in HALT.
- flush_cnt increments at each edge with step & mem_branch_taken. It saturates at 2^CNTW-1.
- Simultaneous events:
  - load_use & branch: the branch wins; the load-use instr is squashed, so no bubble is needed.
  - wb_halt & branch: the halt wins (step=0).
- nRST asserted mid-stall clears dmem_done and the counters immediately; after release the FSM is in RUN.

Test Plan:
- No hazards, ihit=1, mem_acc=0, 10 cycles -> all EN=1, pc_en=1, no FLUSH, stall_cnt=0.
- ex_dREN=1, ex_wsel=5, id_rs=5, ihit=1 -> IF_EN=0, pc_en=0, ID_FLUSH=1, ID_EN=1 for one cycle; stall_cnt=1.
  - Same with ex_wsel=0 -> no stall.
- mem_dREN=1, ihit=0, dhit=1 at cycle 2 -> dmem_done=1, dmemREN drops at cycle 3.
  - ihit=1 at cycle 4 -> step, dmem_done clears; stall_cnt=3.
- mem_branch_taken=1 with load_use=1, ihit=1 -> IF/ID/EX_FLUSH=1, pc_redirect=1, no bubble; flush_cnt=1.
- wb_halt=1 -> next cycle halt=1; imemREN=dmemREN=0 and all EN=0 for 20 cycles despite ihit=1. nRST pulse -> RUN, halt=0.
- Force 2^CNTW+3 stall cycles (CNTW=4 override) -> stall_cnt holds at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: stage enables/flushes,
// PC control, memory request gating, RUN/HALT FSM and saturating perf counters.
module pipeline_hazard_ctrl #(
   parameter int REGW = 5,
   parameter int CNTW = 16
) (
   input  logic            CLK,
   input  logic            nRST,
   input  logic            ihit,
   input  logic            dhit,
   input  logic [REGW-1:0] id_rs,
   input  logic [REGW-1:0] id_rt,
   input  logic            id_uses_rt,
   input  logic            ex_dREN,
   input  logic [REGW-1:0] ex_wsel,
   input  logic            mem_dREN,
   input  logic            mem_dWEN,
   input  logic            mem_branch_taken,
   input  logic            wb_halt,
   output logic            IF_EN,
   output logic            ID_EN,
   output logic            EX_EN,
   output logic            MEM_EN,
   output logic            IF_FLUSH,
   output logic            ID_FLUSH,
   output logic            EX_FLUSH,
   output logic            MEM_FLUSH,
   output logic            pc_en,
   output logic            pc_redirect,
   output logic            imemREN,
   output logic            dmemREN,
   output logic            dmemWEN,
   output logic            halt,
   output logic [CNTW-1:0] stall_cnt,
   output logic [CNTW-1:0] flush_cnt
);

   typedef enum logic {
      RUN_S  = 1'b0,
      HALT_S = 1'b1
   } state_t;

   state_t          state_q;
   logic            halt_q;
   logic            dmem_done_q, dmem_done_d;
   logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;

   logic run;
   logic mem_acc;
   logic dready;
   logic load_use;
   logic step;
   logic stall_inc;
   logic flush_inc;

   assign run      = (state_q == RUN_S);
   assign mem_acc  = mem_dREN | mem_dWEN;
   assign dready   = !mem_acc | dhit | dmem_done_q;
   assign load_use = ex_dREN && (ex_wsel != '0) &&
                     ((ex_wsel == id_rs) || (id_uses_rt && (ex_wsel == id_rt)));
   assign step     = run & !wb_halt & ihit & dready;

   // A squashing branch removes the dependent instr, so it needs no bubble.
   assign stall_inc = run & (!step | (load_use & !mem_branch_taken));
   assign flush_inc = step & mem_branch_taken;

   // NOTE: every signal driven in always_comb gets a default first, otherwise
   // a path that leaves it unassigned infers a latch.
   always_comb begin
      IF_EN       = 1'b0;
      ID_EN       = 1'b0;
      EX_EN       = 1'b0;
      MEM_EN      = 1'b0;
      IF_FLUSH    = 1'b0;
      ID_FLUSH    = 1'b0;
      EX_FLUSH    = 1'b0;
      MEM_FLUSH   = 1'b0;
      pc_en       = 1'b0;
      pc_redirect = 1'b0;
      if (step) begin
         ID_EN  = 1'b1;
         EX_EN  = 1'b1;
         MEM_EN = 1'b1;
         if (mem_branch_taken) begin
            IF_EN       = 1'b1;
            IF_FLUSH    = 1'b1;
            ID_FLUSH    = 1'b1;
            EX_FLUSH    = 1'b1;
            pc_en       = 1'b1;
            pc_redirect = 1'b1;
         end else if (load_use) begin
            ID_FLUSH = 1'b1;
         end else begin
            IF_EN = 1'b1;
            pc_en = 1'b1;
         end
      end
   end

   assign imemREN = run & !wb_halt;
   assign dmemREN = run & !wb_halt & mem_dREN & !dmem_done_q;
   assign dmemWEN = run & !wb_halt & mem_dWEN & !dmem_done_q;

   // Remember a dmem response that arrived while the pipe was frozen on imem.
   always_comb begin
      dmem_done_d = dmem_done_q;
      if (step)
         dmem_done_d = 1'b0;
      else if (dhit && mem_acc)
         dmem_done_d = 1'b1;
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_inc && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNTW'(1);
      if (flush_inc && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + CNTW'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= RUN_S;
         halt_q  <= 1'b0;
      end else begin
         case (state_q)
            RUN_S: begin
               if (wb_halt) begin
                  state_q <= HALT_S;
                  halt_q  <= 1'b1;
               end
            end
            HALT_S: begin
               state_q <= HALT_S;
               halt_q  <= 1'b1;
            end
            default: begin
               state_q <= RUN_S;
               halt_q  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         dmem_done_q <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         dmem_done_q <= dmem_done_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign halt      = halt_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
